ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg.sv | 126 ++++++++++++
 tb/tb_ex_mem_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register. It replicates store data across byte lanes and traps
// misaligned memory accesses, holding the pipeline until the trap is acknowledged.
module ex_mem_reg #(
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        CLR,
   input  logic        stall,
   input  logic        flush,
   input  logic        exc_ack,
   input  logic        ex_valid,
   input  logic        ex_RegWrite,
   input  logic        ex_MemWrite,
   input  logic        ex_MemtoReg,
   input  logic        ex_UnsignedExt_Mem,
   input  logic        ex_Byte,
   input  logic        ex_Half,
   input  logic [31:0] ex_alu,
   input  logic [31:0] ex_store,
   input  logic [4:0]  ex_rd,
   output logic [31:0] R1_in,
   output logic [31:0] data_in,
   output logic        valid,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        MemtoReg,
   output logic        UnsignedExt_Mem,
   output logic        Byte,
   output logic        Half,
   output logic [4:0]  rd,
   output logic        exc,
   output logic [31:0] exc_addr,
   output logic        stall_req
);

   typedef enum logic {RUN, TRAP} state_t;

   typedef struct packed {
      logic        valid;
      logic        reg_write;
      logic        mem_write;
      logic        mem_to_reg;
      logic        unsigned_ext;
      logic        byte_acc;
      logic        half_acc;
      logic [4:0]  rd;
      logic [31:0] addr;
      logic [31:0] data;
   } stage_t;

   state_t      state;
   stage_t      q;
   stage_t      load;
   logic        is_half;
   logic        is_word;
   logic        misaligned;
   logic [31:0] store_lanes;

   // Byte wins when both size bits are set
   always_comb begin
      is_half = ex_Half & ~ex_Byte;
      is_word = ~ex_Byte & ~ex_Half;
      store_lanes = ex_store;
      if (ex_Byte)
         store_lanes = {4{ex_store[7:0]}};
      else if (ex_Half)
         store_lanes = {2{ex_store[15:0]}};
      misaligned = ALIGN_CHECK && ex_valid && (ex_MemWrite || ex_MemtoReg) &&
                   ((is_half && ex_alu[0]) || (is_word && (ex_alu[1:0] != 2'b00)));
      load = '{valid: ex_valid, reg_write: ex_RegWrite, mem_write: ex_MemWrite,
               mem_to_reg: ex_MemtoReg, unsigned_ext: ex_UnsignedExt_Mem,
               byte_acc: ex_Byte, half_acc: ex_Half, rd: ex_rd,
               addr: ex_alu, data: store_lanes};
   end

   always_ff @(posedge clk) begin
      if (CLR) begin
         state    <= RUN;
         q        <= '0;
         exc      <= 1'b0;
         exc_addr <= '0;
      end else begin
         case (state)
            RUN: begin
               if (flush) begin
                  q <= '0;
               end else if (stall) begin
                  q <= q;
               end else if (misaligned) begin
                  q        <= '0;
                  exc      <= 1'b1;
                  exc_addr <= ex_alu;
                  state    <= TRAP;
               end else begin
                  q <= load;
               end
            end
            TRAP: begin
               // Bubble is held; only the acknowledge releases the pipeline
               q <= '0;
               if (exc_ack) begin
                  exc   <= 1'b0;
                  state <= RUN;
               end
            end
            default: begin
               q     <= '0;
               state <= RUN;
            end
         endcase
      end
   end

   assign stall_req       = (state == TRAP);
   assign valid           = q.valid;
   assign RegWrite        = q.reg_write;
   assign MemWrite        = q.mem_write;
   assign MemtoReg        = q.mem_to_reg;
   assign UnsignedExt_Mem = q.unsigned_ext;
   assign Byte            = q.byte_acc;
   assign Half            = q.half_acc;
   assign rd              = q.rd;
   assign R1_in           = q.addr;
   assign data_in         = q.data;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: one instance with alignment trapping and one
// without, both driven by the same stimulus.
module tb_ex_mem_reg;

   logic        clk = 1'b0;
   logic        CLR, stall, flush, exc_ack;
   logic        ex_valid, ex_RegWrite, ex_MemWrite, ex_MemtoReg;
   logic        ex_UnsignedExt_Mem, ex_Byte, ex_Half;
   logic [31:0] ex_alu, ex_store;
   logic [4:0]  ex_rd;

   logic [31:0] a_R1_in, a_data_in, a_exc_addr, b_R1_in, b_data_in, b_exc_addr;
   logic        a_valid, a_RegWrite, a_MemWrite, a_MemtoReg, a_Uns, a_Byte, a_Half;
   logic        b_valid, b_RegWrite, b_MemWrite, b_MemtoReg, b_Uns, b_Byte, b_Half;
   logic [4:0]  a_rd, b_rd;
   logic        a_exc, a_stall_req, b_exc, b_stall_req;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ex_mem_reg #(.ALIGN_CHECK(1'b1)) u_chk (
      .clk(clk), .CLR(CLR), .stall(stall), .flush(flush), .exc_ack(exc_ack),
      .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
      .ex_MemtoReg(ex_MemtoReg), .ex_UnsignedExt_Mem(ex_UnsignedExt_Mem),
      .ex_Byte(ex_Byte), .ex_Half(ex_Half), .ex_alu(ex_alu), .ex_store(ex_store),
      .ex_rd(ex_rd), .R1_in(a_R1_in), .data_in(a_data_in), .valid(a_valid),
      .RegWrite(a_RegWrite), .MemWrite(a_MemWrite), .MemtoReg(a_MemtoReg),
      .UnsignedExt_Mem(a_Uns), .Byte(a_Byte), .Half(a_Half), .rd(a_rd),
      .exc(a_exc), .exc_addr(a_exc_addr), .stall_req(a_stall_req));

   ex_mem_reg #(.ALIGN_CHECK(1'b0)) u_nochk (
      .clk(clk), .CLR(CLR), .stall(stall), .flush(flush), .exc_ack(exc_ack),
      .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
      .ex_MemtoReg(ex_MemtoReg), .ex_UnsignedExt_Mem(ex_UnsignedExt_Mem),
      .ex_Byte(ex_Byte), .ex_Half(ex_Half), .ex_alu(ex_alu), .ex_store(ex_store),
      .ex_rd(ex_rd), .R1_in(b_R1_in), .data_in(b_data_in), .valid(b_valid),
      .RegWrite(b_RegWrite), .MemWrite(b_MemWrite), .MemtoReg(b_MemtoReg),
      .UnsignedExt_Mem(b_Uns), .Byte(b_Byte), .Half(b_Half), .rd(b_rd),
      .exc(b_exc), .exc_addr(b_exc_addr), .stall_req(b_stall_req));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic mw, input logic m2r,
                        input logic by, input logic hf, input logic [31:0] alu,
                        input logic [31:0] st, input logic [4:0] d);
      ex_valid = v; ex_RegWrite = rw; ex_MemWrite = mw; ex_MemtoReg = m2r;
      ex_UnsignedExt_Mem = 1'b0; ex_Byte = by; ex_Half = hf;
      ex_alu = alu; ex_store = st; ex_rd = d;
   endtask

   initial begin
      CLR = 1'b1; stall = 1'b1; flush = 1'b1; exc_ack = 1'b0;
      drive(1, 1, 1, 1, 0, 0, 32'h0000_0102, 32'hFFFF_FFFF, 5'd31);
      tick();
      check("rst_valid", 32'(a_valid), 32'd0);
      check("rst_R1_in", a_R1_in, 32'd0);
      check("rst_data_in", a_data_in, 32'd0);
      check("rst_exc", 32'(a_exc), 32'd0);
      check("rst_stall_req", 32'(a_stall_req), 32'd0);

      CLR = 1'b0; stall = 1'b0; flush = 1'b0;
      drive(1, 1, 0, 1, 0, 0, 32'h0000_1004, 32'h0, 5'd5);
      tick();
      check("lw_valid", 32'(a_valid), 32'd1);
      check("lw_memtoreg", 32'(a_MemtoReg), 32'd1);
      check("lw_R1_in", a_R1_in, 32'h0000_1004);
      check("lw_rd", 32'(a_rd), 32'd5);
      check("lw_exc", 32'(a_exc), 32'd0);

      drive(1, 0, 1, 0, 1, 0, 32'h0000_0003, 32'h1234_56AB, 5'd0);
      tick();
      check("sb_data_in", a_data_in, 32'hABAB_ABAB);
      check("sb_memwrite", 32'(a_MemWrite), 32'd1);
      check("sb_R1_in", a_R1_in, 32'h0000_0003);

      drive(1, 0, 1, 0, 0, 1, 32'h0000_0002, 32'h0000_BEEF, 5'd0);
      tick();
      check("sh_data_in", a_data_in, 32'hBEEF_BEEF);
      check("sh_exc", 32'(a_exc), 32'd0);

      // both size bits set: byte access, odd address must not trap
      drive(1, 0, 1, 0, 1, 1, 32'h0000_0001, 32'h0000_00CD, 5'd0);
      tick();
      check("bh_data_in", a_data_in, 32'hCDCD_CDCD);
      check("bh_exc", 32'(a_exc), 32'd0);
      check("bh_memwrite", 32'(a_MemWrite), 32'd1);

      drive(1, 0, 1, 0, 0, 0, 32'h0000_0008, 32'hCAFE_F00D, 5'd0);
      tick();
      check("sw_data_in", a_data_in, 32'hCAFE_F00D);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, (i == 1), (i != 1), (i == 2), 0, 32'h0000_2000 + 32'(i) * 32'h102 + 32'(i == 1),
               32'h5555_0000 + 32'(i), 5'(7 + i));
         tick();
         check("stall_R1_in", a_R1_in, 32'h0000_0008);
         check("stall_data_in", a_data_in, 32'hCAFE_F00D);
         check("stall_exc", 32'(a_exc), 32'd0);
      end

      flush = 1'b1;
      tick();
      check("flush_valid", 32'(a_valid), 32'd0);
      check("flush_memwrite", 32'(a_MemWrite), 32'd0);
      check("flush_R1_in", a_R1_in, 32'd0);

      stall = 1'b0; flush = 1'b0;
      drive(0, 0, 1, 0, 0, 0, 32'h0000_0002, 32'h0, 5'd0);
      tick();
      check("inv_noexc", 32'(a_exc), 32'd0);
      check("inv_valid", 32'(a_valid), 32'd0);

      drive(1, 0, 1, 0, 0, 0, 32'h0000_0102, 32'h0000_0011, 5'd0);
      tick();
      check("mis_memwrite", 32'(a_MemWrite), 32'd0);
      check("mis_valid", 32'(a_valid), 32'd0);
      check("mis_exc", 32'(a_exc), 32'd1);
      check("mis_exc_addr", a_exc_addr, 32'h0000_0102);
      check("mis_stall_req", 32'(a_stall_req), 32'd1);
      check("nochk_memwrite", 32'(b_MemWrite), 32'd1);
      check("nochk_exc", 32'(b_exc), 32'd0);

      for (int i = 0; i < 5; i++) begin
         flush = (i == 2);
         stall = (i == 3);
         drive(1, 1, 0, 1, 0, 0, 32'h0000_0300 + 32'(i * 4), 32'h0, 5'd4);
         tick();
         check("trap_exc", 32'(a_exc), 32'd1);
         check("trap_valid", 32'(a_valid), 32'd0);
         check("trap_stall_req", 32'(a_stall_req), 32'd1);
      end
      flush = 1'b0; stall = 1'b0;

      exc_ack = 1'b1;
      tick();
      check("ack_exc", 32'(a_exc), 32'd0);
      check("ack_stall_req", 32'(a_stall_req), 32'd0);
      check("ack_exc_addr", a_exc_addr, 32'h0000_0102);

      // acknowledge left high in RUN has no effect
      drive(1, 1, 0, 1, 0, 0, 32'h0000_0040, 32'h0, 5'd9);
      tick();
      check("resume_valid", 32'(a_valid), 32'd1);
      check("resume_R1_in", a_R1_in, 32'h0000_0040);
      check("resume_rd", 32'(a_rd), 32'd9);
      check("resume_exc", 32'(a_exc), 32'd0);
      exc_ack = 1'b0;

      drive(1, 1, 0, 1, 0, 1, 32'h0000_0001, 32'h0, 5'd2);
      tick();
      check("lh_mis_exc", 32'(a_exc), 32'd1);
      check("nochk_lh_memtoreg", 32'(b_MemtoReg), 32'd1);
      check("nochk_lh_exc", 32'(b_exc), 32'd0);
      check("nochk_lh_R1_in", b_R1_in, 32'h0000_0001);

      CLR = 1'b1; stall = 1'b1;
      tick();
      check("clr_trap_exc", 32'(a_exc), 32'd0);
      check("clr_trap_stall_req", 32'(a_stall_req), 32'd0);
      check("clr_trap_exc_addr", a_exc_addr, 32'd0);
      check("clr_trap_R1_in", a_R1_in, 32'd0);
      check("clr_trap_rd", 32'(a_rd), 32'd0);

      CLR = 1'b0; stall = 1'b0;
      drive(1, 1, 0, 1, 0, 0, 32'h0000_0044, 32'h0, 5'd3);
      tick();
      check("post_clr_valid", 32'(a_valid), 32'd1);
      check("post_clr_R1_in", a_R1_in, 32'h0000_0044);
      check("post_clr_rd", 32'(a_rd), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
